// File: rtl/beep_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : beep_sequencer
// Brief    : Note sequencer feeding the PWM DAC. The host queues notes
//            (half-period, duration, amplitude) in a small FIFO; the block
//            plays them back-to-back as square waves at the DAC sample rate
//            and gates the DAC enable. Single clock domain (pwmclk).
// Options  : BEEP_SEQ_GAP_EN - insert GAP_SAMPLES silent ticks after every
//            played note (DAC stays enabled during the gap).
// Revision : 1.0 - initial release
// ============================================================================
module beep_sequencer #(
    parameter int SAMPLE_DIV  = 2500,
    parameter int DUR_UNIT    = 44,
    parameter int FIFO_DEPTH  = 8
`ifdef BEEP_SEQ_GAP_EN
    ,
    parameter int GAP_SAMPLES = 441
`endif
) (
    input  logic                          pwmclk,
    input  logic                          rst,
    input  logic                          note_valid,
    output logic                          note_ready,
    input  logic [11:0]                   note_period,
    input  logic [11:0]                   note_dur,
    input  logic [7:0]                    note_amp,
    input  logic                          abort,
    output logic [7:0]                    sample,
    output logic                          dac_enable,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int ADDR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = ADDR_W + 1;
    localparam int DIV_W   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int UNIT_W  = (DUR_UNIT > 1) ? $clog2(DUR_UNIT) : 1;
    localparam int ENTRY_W = 32;

    localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [UNIT_W-1:0] UNIT_MAX = UNIT_W'(DUR_UNIT - 1);
    localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(FIFO_DEPTH);

`ifdef BEEP_SEQ_GAP_EN
    localparam int GAP_W = (GAP_SAMPLES > 1) ? $clog2(GAP_SAMPLES) : 1;
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_SAMPLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PLAY = 2'd2,
        S_GAP  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PLAY = 2'd2
    } state_t;
`endif

    // ------------------------------------------------------------------------
    // Note FIFO
    // ------------------------------------------------------------------------
    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q,  level_d;

    logic               w_push;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_head;
    logic [11:0]        w_head_period;
    logic [11:0]        w_head_dur;
    logic [7:0]         w_head_amp;
    logic               w_more_queued;

    // ------------------------------------------------------------------------
    // Playback state
    // ------------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [11:0]        period_q, period_d;
    logic [11:0]        dur_q, dur_d;
    logic [7:0]         amp_q, amp_d;
    logic               phase_q, phase_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [11:0]        half_cnt_q, half_cnt_d;
    logic [UNIT_W-1:0]  unit_cnt_q, unit_cnt_d;
    logic [11:0]        dur_cnt_q, dur_cnt_d;
`ifdef BEEP_SEQ_GAP_EN
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
`endif

    logic [7:0]         sample_q, sample_d;
    logic               dac_enable_q, dac_enable_d;
    logic               busy_q, busy_d;

    logic               w_tick;
    logic               w_note_end;

    // A push racing abort is dropped; the head is only consumed in LOAD.
    assign w_push        = note_valid && note_ready && !abort;
    assign w_pop         = (state_q == S_LOAD) && !abort;
    assign w_head        = mem_q[rd_ptr_q];
    assign w_head_period = w_head[31:20];
    assign w_head_dur    = w_head[19:8];
    assign w_head_amp    = w_head[7:0];
    // Look at the level after this cycle's push/pop so a note pushed while
    // the previous one ends chains straight into LOAD.
    assign w_more_queued = (level_d != '0);

    assign w_tick     = (div_cnt_q == DIV_MAX);
    assign w_note_end = w_tick && (unit_cnt_q == UNIT_MAX) &&
                        ((dur_cnt_q + 12'd1) == dur_q);

    assign note_ready = (level_q != LVL_FULL);
    assign fifo_level = level_q;
    assign sample     = sample_q;
    assign dac_enable = dac_enable_q;
    assign busy       = busy_q;

    // Note storage: write the incoming note at the write pointer.
    always_ff @(posedge pwmclk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {note_period, note_dur, note_amp};
        end
    end

    // FIFO pointer and level update; abort empties the queue.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        if (abort) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
    end

    // Next-state and counter logic of the playback FSM.
    always_comb begin
        state_d    = state_q;
        period_d   = period_q;
        dur_d      = dur_q;
        amp_d      = amp_q;
        phase_d    = phase_q;
        div_cnt_d  = div_cnt_q;
        half_cnt_d = half_cnt_q;
        unit_cnt_d = unit_cnt_q;
        dur_cnt_d  = dur_cnt_q;
`ifdef BEEP_SEQ_GAP_EN
        gap_cnt_d  = gap_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (level_q != '0) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                period_d   = w_head_period;
                dur_d      = w_head_dur;
                amp_d      = w_head_amp;
                phase_d    = 1'b1;
                div_cnt_d  = '0;
                half_cnt_d = '0;
                unit_cnt_d = '0;
                dur_cnt_d  = '0;
                // Zero-duration notes are consumed without playing anything.
                if (w_head_dur == 12'd0) begin
                    state_d = w_more_queued ? S_LOAD : S_IDLE;
                end else begin
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                div_cnt_d = w_tick ? '0 : div_cnt_q + 1'b1;
                if (w_tick) begin
                    // period==0 never matches in practice; sample stays 0 for rests.
                    if (half_cnt_q == (period_q - 12'd1)) begin
                        phase_d    = ~phase_q;
                        half_cnt_d = '0;
                    end else begin
                        half_cnt_d = half_cnt_q + 12'd1;
                    end
                    if (unit_cnt_q == UNIT_MAX) begin
                        unit_cnt_d = '0;
                        dur_cnt_d  = dur_cnt_q + 12'd1;
                    end else begin
                        unit_cnt_d = unit_cnt_q + 1'b1;
                    end
                end
                if (w_note_end) begin
`ifdef BEEP_SEQ_GAP_EN
                    state_d   = S_GAP;
                    gap_cnt_d = '0;
`else
                    state_d   = w_more_queued ? S_LOAD : S_IDLE;
`endif
                end
            end
`ifdef BEEP_SEQ_GAP_EN
            S_GAP: begin
                div_cnt_d = w_tick ? '0 : div_cnt_q + 1'b1;
                if (w_tick) begin
                    if (gap_cnt_q == GAP_MAX) begin
                        state_d = w_more_queued ? S_LOAD : S_IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // abort overrides whatever the FSM decided this cycle.
        if (abort) begin
            state_d    = S_IDLE;
            phase_d    = 1'b0;
            div_cnt_d  = '0;
            half_cnt_d = '0;
            unit_cnt_d = '0;
            dur_cnt_d  = '0;
`ifdef BEEP_SEQ_GAP_EN
            gap_cnt_d  = '0;
`endif
        end
    end

    // Registered outputs, derived from the current state (one-cycle lag).
    always_comb begin
        sample_d     = (state_q == S_PLAY && period_q != 12'd0 && phase_q) ? amp_q : 8'd0;
        dac_enable_d = (state_q != S_IDLE);
        busy_d       = (state_q != S_IDLE) || (level_q != '0);
        if (abort) begin
            sample_d     = 8'd0;
            dac_enable_d = 1'b0;
            busy_d       = 1'b0;
        end
    end

    // State, counter, FIFO-pointer and output registers.
    always_ff @(posedge pwmclk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            period_q     <= '0;
            dur_q        <= '0;
            amp_q        <= '0;
            phase_q      <= 1'b0;
            div_cnt_q    <= '0;
            half_cnt_q   <= '0;
            unit_cnt_q   <= '0;
            dur_cnt_q    <= '0;
`ifdef BEEP_SEQ_GAP_EN
            gap_cnt_q    <= '0;
`endif
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            sample_q     <= '0;
            dac_enable_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            dur_q        <= dur_d;
            amp_q        <= amp_d;
            phase_q      <= phase_d;
            div_cnt_q    <= div_cnt_d;
            half_cnt_q   <= half_cnt_d;
            unit_cnt_q   <= unit_cnt_d;
            dur_cnt_q    <= dur_cnt_d;
`ifdef BEEP_SEQ_GAP_EN
            gap_cnt_q    <= gap_cnt_d;
`endif
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            sample_q     <= sample_d;
            dac_enable_q <= dac_enable_d;
            busy_q       <= busy_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_beep_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_beep_sequencer
// Brief    : Directed self-checking bench for beep_sequencer
//            (SAMPLE_DIV=4, DUR_UNIT=2, FIFO_DEPTH=4, GAP_SAMPLES=3).
//            Honours BEEP_SEQ_GAP_EN when it is defined for the build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_beep_sequencer;

    localparam int LIMIT = 500;
`ifdef BEEP_SEQ_GAP_EN
    // 3 gap ticks of 4 clocks, plus the LOAD cycle of the next note.
    localparam int GAP_ZEROS = 13;
`else
    localparam int GAP_ZEROS = 1;
`endif

    logic        pwmclk = 1'b0;
    logic        rst = 1'b1;
    logic        note_valid = 1'b0;
    logic        note_ready;
    logic [11:0] note_period = '0;
    logic [11:0] note_dur = '0;
    logic [7:0]  note_amp = '0;
    logic        abort = 1'b0;
    logic [7:0]  sample;
    logic        dac_enable;
    logic        busy;
    logic [2:0]  fifo_level;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] t1_pat [6] = '{8'd200, 8'd200, 8'd0, 8'd0, 8'd200, 8'd200};

    beep_sequencer #(
        .SAMPLE_DIV  (4),
        .DUR_UNIT    (2),
`ifdef BEEP_SEQ_GAP_EN
        .GAP_SAMPLES (3),
`endif
        .FIFO_DEPTH  (4)
    ) dut (
        .pwmclk      (pwmclk),
        .rst         (rst),
        .note_valid  (note_valid),
        .note_ready  (note_ready),
        .note_period (note_period),
        .note_dur    (note_dur),
        .note_amp    (note_amp),
        .abort       (abort),
        .sample      (sample),
        .dac_enable  (dac_enable),
        .busy        (busy),
        .fifo_level  (fifo_level)
    );

    always #5 pwmclk = ~pwmclk;

    task automatic tick();
        @(posedge pwmclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Hold a note on the push port until it is accepted.
    task automatic push(input logic [11:0] p, input logic [11:0] d, input logic [7:0] a);
        int n;
        note_period = p;
        note_dur    = d;
        note_amp    = a;
        note_valid  = 1'b1;
        n = 0;
        while (!note_ready && n < LIMIT) begin
            tick();
            n++;
        end
        tick();
        note_valid = 1'b0;
        chk("push_accept", n < LIMIT, 1);
    endtask

    task automatic wait_sample_nz(input string tag);
        int n = 0;
        while (sample == 8'd0 && n < LIMIT) begin
            tick();
            n++;
        end
        chk(tag, n < LIMIT, 1);
    endtask

    task automatic wait_sample_z(input string tag);
        int n = 0;
        while (sample != 8'd0 && n < LIMIT) begin
            tick();
            n++;
        end
        chk(tag, n < LIMIT, 1);
    endtask

    task automatic wait_dac_low(input string tag);
        int n = 0;
        while (dac_enable && n < LIMIT) begin
            tick();
            n++;
        end
        chk(tag, n < LIMIT, 1);
    endtask

    task automatic count_high(output int n);
        n = 0;
        while (sample != 8'd0 && n < LIMIT) begin
            n++;
            tick();
        end
    endtask

    task automatic count_silent_enabled(output int n);
        n = 0;
        while (sample == 8'd0 && dac_enable && n < LIMIT) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        int seen;

        // Reset values
        repeat (3) tick();
        chk("rst_sample", sample, 0);
        chk("rst_dac", dac_enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ready", note_ready, 1);
        rst = 1'b0;
        tick();

        // 1: single note {2,3,200}
        push(12'd2, 12'd3, 8'd200);
        chk("t1_level", fifo_level, 1);
        chk("t1_busy_lag", busy, 0);
        tick();
        chk("t1_busy_on", busy, 1);
        chk("t1_dac_load", dac_enable, 0);
        tick();
        chk("t1_dac_on", dac_enable, 1);
        chk("t1_sample_load", sample, 0);
        tick();
        for (int i = 0; i < 24; i++) begin
            chk("t1_sample", sample, t1_pat[i / 4]);
            chk("t1_dac", dac_enable, 1);
            chk("t1_busy", busy, 1);
            tick();
        end
        chk("t1_dac_off", dac_enable, 0);
        chk("t1_sample_off", sample, 0);
        chk("t1_busy_off", busy, 0);

        // period==1 toggles every tick: 4 clocks high, then 4 low
        push(12'd1, 12'd1, 8'd33);
        wait_sample_nz("p1_wait");
        chk("p1_amp", sample, 33);
        count_high(n);
        chk("p1_high_len", n, 4);
        wait_dac_low("p1_end");

        // 3: rest note then a zero-duration note then a marker
        push(12'd0, 12'd1, 8'd99);
        push(12'd2, 12'd0, 8'd77);
        push(12'd4, 12'd1, 8'd55);
        chk("t3_dac_on", dac_enable, 1);
        count_silent_enabled(n);
        // LOAD + 8 rest cycles + LOAD(dur=0) + LOAD(marker) -> 11 silent enabled
        chk("t3_silent_len", n, 11);
        chk("t3_marker", sample, 55);
        wait_dac_low("t3_end");

        // 2: fill the queue while a long note plays
        push(12'd4, 12'd2, 8'd5);
        wait_sample_nz("t2_wait_a");
        chk("t2_a_amp", sample, 5);
        for (int i = 0; i < 4; i++) begin
            push(12'd4, 12'd1, 8'(10 * (i + 1)));
            chk("t2_level", fifo_level, i + 1);
        end
        chk("t2_full_ready", note_ready, 0);
        push(12'd4, 12'd1, 8'd50);
        chk("t2_level_peak", fifo_level, 4);
        for (int i = 0; i < 5; i++) begin
            wait_sample_nz("t2_wait_note");
            chk("t2_order", sample, 10 * (i + 1));
            wait_sample_z("t2_note_end");
        end
        wait_dac_low("t2_end");
        chk("t2_level_end", fifo_level, 0);

        // 4: abort mid-play with 3 queued, push in the same cycle
        push(12'd4, 12'd4, 8'd60);
        wait_sample_nz("t4_wait");
        chk("t4_amp", sample, 60);
        push(12'd4, 12'd1, 8'd61);
        push(12'd4, 12'd1, 8'd62);
        push(12'd4, 12'd1, 8'd63);
        chk("t4_level_q", fifo_level, 3);
        abort       = 1'b1;
        note_valid  = 1'b1;
        note_period = 12'd4;
        note_dur    = 12'd1;
        note_amp    = 8'd99;
        tick();
        abort      = 1'b0;
        note_valid = 1'b0;
        chk("t4_level", fifo_level, 0);
        chk("t4_dac", dac_enable, 0);
        chk("t4_sample", sample, 0);
        chk("t4_busy", busy, 0);
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (sample != 8'd0 || dac_enable) seen++;
            tick();
        end
        chk("t4_quiet", seen, 0);
        chk("t4_level_after", fifo_level, 0);

        // 5: reset mid-note, then normal playback
        push(12'd2, 12'd2, 8'd70);
        wait_sample_nz("t5_wait");
        chk("t5_amp", sample, 70);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_sample", sample, 0);
        chk("t5_dac", dac_enable, 0);
        chk("t5_busy", busy, 0);
        chk("t5_level", fifo_level, 0);
        chk("t5_ready", note_ready, 1);
        push(12'd2, 12'd1, 8'd80);
        wait_sample_nz("t5_wait2");
        chk("t5_amp2", sample, 80);
        count_high(n);
        chk("t5_high_len", n, 8);
        wait_dac_low("t5_end");

        // 6: two queued notes, silence between them
        push(12'd2, 12'd1, 8'd90);
        push(12'd2, 12'd1, 8'd91);
        wait_sample_nz("t6_wait");
        chk("t6_amp1", sample, 90);
        count_high(n);
        chk("t6_high_len", n, 8);
        count_silent_enabled(n);
        chk("t6_gap_len", n, GAP_ZEROS);
        chk("t6_amp2", sample, 91);
        wait_dac_low("t6_end");
        tick();
        chk("t6_busy_end", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
